// File: rtl/risc16_mem_arbiter.sv
// ---------------------------------------------------------------------------
// risc16_mem_arbiter
//
// Purpose:
//   Single-port arbiter placed directly in front of RiSC16_memory. It merges
//   the instruction-fetch read port (if_*) and the load/store data port (ls_*)
//   into one memory port. Requests use a req/gnt handshake and are issued
//   through registers. A {valid, port} tag pipeline, matched to the memory
//   read latency, steers mem_dataOut back to the port that issued each read.
//   The data port has priority. A streak limit stops fetch from starving.
//
// Parameters:
//   WORD_LENGTH   - width of data and address.
//   READ_LATENCY  - cycles from the memory sampling an address to valid
//                   dataOut (0 = combinational read, 1 = synchronous read).
//                   Legal range 0..3.
//   MAX_LS_STREAK - maximum consecutive data-port grants while if_req is
//                   pending. Legal range 1..15.
//
// Ports:
//   clk, rst                 - clock (rising edge); async active-low reset
//   if_req/if_addr           - fetch read request, held until granted
//   if_gnt                   - fetch accepted this cycle
//   if_rvalid/if_rdata       - fetch read return (one-cycle pulse)
//   ls_req/ls_we/ls_addr/ls_wdata - data request, held until granted
//   ls_gnt                   - data request accepted this cycle
//   ls_rvalid/ls_rdata       - load return (one-cycle pulse, reads only)
//   mem_address/mem_dataIn/mem_writeEn - registered memory command
//   mem_dataOut              - memory read data
//
// Optional feature (macro RISC16_ARB_STATS_EN):
//   Adds if_stall_cnt / ls_stall_cnt. Each saturating 16-bit counter counts
//   the cycles in which its port requested but was not granted.
// ---------------------------------------------------------------------------
module risc16_mem_arbiter #(
  parameter int WORD_LENGTH   = 16,
  parameter int READ_LATENCY  = 1,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [WORD_LENGTH-1:0] if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  output logic [WORD_LENGTH-1:0] if_rdata,
  input  logic                   ls_req,
  input  logic                   ls_we,
  input  logic [WORD_LENGTH-1:0] ls_addr,
  input  logic [WORD_LENGTH-1:0] ls_wdata,
  output logic                   ls_gnt,
  output logic                   ls_rvalid,
  output logic [WORD_LENGTH-1:0] ls_rdata,
  output logic [WORD_LENGTH-1:0] mem_address,
  output logic [WORD_LENGTH-1:0] mem_dataIn,
  output logic                   mem_writeEn,
  input  logic [WORD_LENGTH-1:0] mem_dataOut
`ifdef RISC16_ARB_STATS_EN
  ,
  output logic [15:0]            if_stall_cnt,
  output logic [15:0]            ls_stall_cnt
`endif
);

  // One tag entry per cycle between the grant edge and the data return.
  localparam int TAG_DEPTH = READ_LATENCY + 1;
  localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_LS_STREAK);

  logic [3:0]             r_streak;
  logic                   w_streakFull;
  logic                   w_ifGnt;
  logic                   w_lsGnt;

  logic [WORD_LENGTH-1:0] r_memAddress;
  logic [WORD_LENGTH-1:0] r_memDataIn;
  logic                   r_memWriteEn;

  logic [TAG_DEPTH-1:0]   r_tagValid;
  logic [TAG_DEPTH-1:0]   r_tagIsLs;
  logic                   w_newTagValid;
  logic                   w_retValid;
  logic                   w_retIsLs;
  logic                   w_ifRvalid;
  logic                   w_lsRvalid;

  logic [WORD_LENGTH-1:0] r_ifRdataHold;
  logic [WORD_LENGTH-1:0] r_lsRdataHold;

  // Arbitration: the data port wins unless fetch is pending and the data
  // port has already taken MAX_LS_STREAK grants in a row.
  assign w_streakFull = (r_streak >= LP_MAX_STREAK);
  assign w_lsGnt      = ls_req && (!if_req || !w_streakFull);
  assign w_ifGnt      = if_req && !w_lsGnt;
  assign if_gnt       = w_ifGnt;
  assign ls_gnt       = w_lsGnt;

  // Streak counter: counts data grants that bypassed a waiting fetch.
  // It clears once fetch wins or stops asking, and saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak <= '0;
    end else if (!if_req || w_ifGnt) begin
      r_streak <= '0;
    end else if (w_lsGnt && !w_streakFull) begin
      r_streak <= r_streak + 4'd1;
    end
  end

  // Issue registers. writeEn is a single-cycle strobe. Address and dataIn
  // hold when nothing is granted, so the memory bus stays quiet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_memAddress <= '0;
      r_memDataIn  <= '0;
      r_memWriteEn <= 1'b0;
    end else begin
      r_memWriteEn <= 1'b0;
      if (w_lsGnt) begin
        r_memAddress <= ls_addr;
        r_memDataIn  <= ls_wdata;
        r_memWriteEn <= ls_we;
      end else if (w_ifGnt) begin
        r_memAddress <= if_addr;
      end
    end
  end

  assign mem_address = r_memAddress;
  assign mem_dataIn  = r_memDataIn;
  assign mem_writeEn = r_memWriteEn;

  // Tag pipeline. Writes and idle cycles push an invalid entry, so the
  // pipeline output lines up exactly with the memory read latency.
  assign w_newTagValid = w_ifGnt || (w_lsGnt && !ls_we);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tagValid <= '0;
      r_tagIsLs  <= '0;
    end else begin
      r_tagValid <= TAG_DEPTH'({r_tagValid, w_newTagValid});
      r_tagIsLs  <= TAG_DEPTH'({r_tagIsLs, w_lsGnt});
    end
  end

  assign w_retValid = r_tagValid[TAG_DEPTH-1];
  assign w_retIsLs  = r_tagIsLs[TAG_DEPTH-1];
  assign w_ifRvalid = w_retValid && !w_retIsLs;
  assign w_lsRvalid = w_retValid && w_retIsLs;
  assign if_rvalid  = w_ifRvalid;
  assign ls_rvalid  = w_lsRvalid;

  // The returning port sees mem_dataOut directly. The other port keeps the
  // last data it received.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ifRdataHold <= '0;
      r_lsRdataHold <= '0;
    end else begin
      if (w_ifRvalid) r_ifRdataHold <= mem_dataOut;
      if (w_lsRvalid) r_lsRdataHold <= mem_dataOut;
    end
  end

  assign if_rdata = w_ifRvalid ? mem_dataOut : r_ifRdataHold;
  assign ls_rdata = w_lsRvalid ? mem_dataOut : r_lsRdataHold;

`ifdef RISC16_ARB_STATS_EN
  logic [15:0] r_ifStallCnt;
  logic [15:0] r_lsStallCnt;

  // Stall statistics: cycles in which a port was requesting but not granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ifStallCnt <= '0;
      r_lsStallCnt <= '0;
    end else begin
      if (if_req && !w_ifGnt && (r_ifStallCnt != 16'hFFFF))
        r_ifStallCnt <= r_ifStallCnt + 16'd1;
      if (ls_req && !w_lsGnt && (r_lsStallCnt != 16'hFFFF))
        r_lsStallCnt <= r_lsStallCnt + 16'd1;
    end
  end

  assign if_stall_cnt = r_ifStallCnt;
  assign ls_stall_cnt = r_lsStallCnt;
`endif

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_risc16_mem_arbiter
//
// Bench for risc16_mem_arbiter. It uses three instances:
//   dutA - READ_LATENCY=1, MAX_LS_STREAK=4, with a synchronous memory model.
//   dutB0 - READ_LATENCY=0, with a combinational read-only memory model.
//   dutB2 - READ_LATENCY=2, with a two-stage read-only memory model.
// dutB0 and dutB2 share one fetch stimulus.
// Stats outputs are checked only when RISC16_ARB_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_risc16_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // dutA signals
  logic        ifReqA, lsReqA, lsWeA;
  logic [15:0] ifAddrA, lsAddrA, lsWdataA;
  logic        ifGntA, ifRvalidA, lsGntA, lsRvalidA, memWeA;
  logic [15:0] ifRdataA, lsRdataA, memAddrA, memDinA, memDoutA;

  // dutB0 / dutB2 signals (shared fetch stimulus)
  logic        ifReqB;
  logic [15:0] ifAddrB;
  logic        ifGntB0, ifRvalidB0, lsGntB0, lsRvalidB0, memWeB0;
  logic [15:0] ifRdataB0, lsRdataB0, memAddrB0, memDinB0, memDoutB0;
  logic        ifGntB2, ifRvalidB2, lsGntB2, lsRvalidB2, memWeB2;
  logic [15:0] ifRdataB2, lsRdataB2, memAddrB2, memDinB2, memDoutB2;
  logic [15:0] pipeB2;

`ifdef RISC16_ARB_STATS_EN
  logic [15:0] ifStallA, lsStallA, ifStallB0, lsStallB0, ifStallB2, lsStallB2;
`endif

  risc16_mem_arbiter #(.WORD_LENGTH(16), .READ_LATENCY(1), .MAX_LS_STREAK(4)) dutA (
    .clk(clk), .rst(rst),
    .if_req(ifReqA), .if_addr(ifAddrA), .if_gnt(ifGntA),
    .if_rvalid(ifRvalidA), .if_rdata(ifRdataA),
    .ls_req(lsReqA), .ls_we(lsWeA), .ls_addr(lsAddrA), .ls_wdata(lsWdataA),
    .ls_gnt(lsGntA), .ls_rvalid(lsRvalidA), .ls_rdata(lsRdataA),
    .mem_address(memAddrA), .mem_dataIn(memDinA), .mem_writeEn(memWeA),
    .mem_dataOut(memDoutA)
`ifdef RISC16_ARB_STATS_EN
    , .if_stall_cnt(ifStallA), .ls_stall_cnt(lsStallA)
`endif
  );

  risc16_mem_arbiter #(.WORD_LENGTH(16), .READ_LATENCY(0), .MAX_LS_STREAK(4)) dutB0 (
    .clk(clk), .rst(rst),
    .if_req(ifReqB), .if_addr(ifAddrB), .if_gnt(ifGntB0),
    .if_rvalid(ifRvalidB0), .if_rdata(ifRdataB0),
    .ls_req(1'b0), .ls_we(1'b0), .ls_addr(16'h0000), .ls_wdata(16'h0000),
    .ls_gnt(lsGntB0), .ls_rvalid(lsRvalidB0), .ls_rdata(lsRdataB0),
    .mem_address(memAddrB0), .mem_dataIn(memDinB0), .mem_writeEn(memWeB0),
    .mem_dataOut(memDoutB0)
`ifdef RISC16_ARB_STATS_EN
    , .if_stall_cnt(ifStallB0), .ls_stall_cnt(lsStallB0)
`endif
  );

  risc16_mem_arbiter #(.WORD_LENGTH(16), .READ_LATENCY(2), .MAX_LS_STREAK(4)) dutB2 (
    .clk(clk), .rst(rst),
    .if_req(ifReqB), .if_addr(ifAddrB), .if_gnt(ifGntB2),
    .if_rvalid(ifRvalidB2), .if_rdata(ifRdataB2),
    .ls_req(1'b0), .ls_we(1'b0), .ls_addr(16'h0000), .ls_wdata(16'h0000),
    .ls_gnt(lsGntB2), .ls_rvalid(lsRvalidB2), .ls_rdata(lsRdataB2),
    .mem_address(memAddrB2), .mem_dataIn(memDinB2), .mem_writeEn(memWeB2),
    .mem_dataOut(memDoutB2)
`ifdef RISC16_ARB_STATS_EN
    , .if_stall_cnt(ifStallB2), .ls_stall_cnt(lsStallB2)
`endif
  );

  // Synchronous memory for dutA. A write commits on the same edge that
  // samples the read address. Address 16'h1222 is preloaded on the first
  // edge.
  logic [15:0] memA [0:65535];
  logic        memInit = 1'b0;

  always @(posedge clk) begin
    if (!memInit) begin
      memA[16'h1222] <= 16'h2000;
      memInit        <= 1'b1;
    end
    if (memWeA) memA[memAddrA] <= memDinA;
    memDoutA <= memA[memAddrA];
  end

  // Read-only memories for the latency variants. Their contents are
  // addr ^ 16'hC3C3.
  assign memDoutB0 = memAddrB0 ^ 16'hC3C3;

  always @(posedge clk) begin
    pipeB2    <= memAddrB2 ^ 16'hC3C3;
    memDoutB2 <= pipeB2;
  end

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic lsReq, input logic lsWe,
                               input logic [15:0] ifAddr, input logic [15:0] lsAddr,
                               input logic [15:0] lsWdata);
    ifReqA   = ifReq;
    lsReqA   = lsReq;
    lsWeA    = lsWe;
    ifAddrA  = ifAddr;
    lsAddrA  = lsAddr;
    lsWdataA = lsWdata;
  endtask

  typedef struct {
    logic        ifReq;
    logic        lsReq;
    logic        lsWe;
    logic [15:0] ifAddr;
    logic [15:0] lsAddr;
    logic [15:0] lsWdata;
    logic        expIfGnt;
    logic        expLsGnt;
    logic [15:0] expAddr;
    logic [15:0] expDin;
    logic        expWe;
  } vec_t;

  vec_t vecs [26];

  initial begin
    // Row format: inputs for this cycle, then the grants expected this cycle,
    // then the memory command expected this cycle (issued by the previous row).
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0201, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0202, 16'h0000, 1'b0, 1'b1, 16'h0201, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0203, 16'h0000, 1'b0, 1'b1, 16'h0202, 16'h0000, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0204, 16'h0000, 1'b0, 1'b1, 16'h0203, 16'h0000, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0205, 16'h0000, 1'b1, 1'b0, 16'h0204, 16'h0000, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0101, 16'h0206, 16'h0000, 1'b0, 1'b1, 16'h0100, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h0101, 16'h0207, 16'h0000, 1'b0, 1'b1, 16'h0206, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h0101, 16'h0208, 16'h0000, 1'b0, 1'b1, 16'h0207, 16'h0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0101, 16'h0209, 16'h0000, 1'b0, 1'b1, 16'h0208, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h0101, 16'h020A, 16'h0000, 1'b1, 1'b0, 16'h0209, 16'h0000, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0101, 16'h0000, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0300, 16'h1234, 1'b0, 1'b1, 16'h0101, 16'h0000, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0300, 16'h1234, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0400, 16'h1234, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0400, 16'h1234, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 16'h0500, 16'h0210, 16'h0000, 1'b0, 1'b1, 16'h0400, 16'h1234, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 16'h0500, 16'h0211, 16'h0000, 1'b0, 1'b1, 16'h0210, 16'h0000, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 16'h0500, 16'h0212, 16'h0000, 1'b0, 1'b1, 16'h0211, 16'h0000, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 16'h0500, 16'h0213, 16'h0000, 1'b0, 1'b1, 16'h0212, 16'h0000, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 16'h0500, 16'h0214, 16'h0000, 1'b0, 1'b1, 16'h0213, 16'h0000, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 16'h0500, 16'h0215, 16'h0000, 1'b0, 1'b1, 16'h0214, 16'h0000, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 16'h0500, 16'h0216, 16'h0000, 1'b0, 1'b1, 16'h0215, 16'h0000, 1'b0};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 16'h0500, 16'h0217, 16'h0000, 1'b0, 1'b1, 16'h0216, 16'h0000, 1'b0};
    vecs[24] = '{1'b1, 1'b1, 1'b0, 16'h0500, 16'h0218, 16'h0000, 1'b1, 1'b0, 16'h0217, 16'h0000, 1'b0};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0500, 16'h0000, 1'b0};

    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    ifReqB  = 1'b0;
    ifAddrB = 16'h0000;

    // Values while reset is held
    #3;
    checkOutput("reset memAddr", memAddrA, 16'h0000);
    checkOutput("reset memDin", memDinA, 16'h0000);
    checkOutput("reset memWe", 16'(memWeA), 16'h0000);
    checkOutput("reset ifRvalid", 16'(ifRvalidA), 16'h0000);
    checkOutput("reset lsRvalid", 16'(lsRvalidA), 16'h0000);
    #9 rst = 1'b1;

    // Table-driven arbitration / issue vectors
    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1;
      applyStimulus(vecs[i].ifReq, vecs[i].lsReq, vecs[i].lsWe,
                    vecs[i].ifAddr, vecs[i].lsAddr, vecs[i].lsWdata);
      @(negedge clk);
      checkOutput($sformatf("row%0d ifGnt", i), 16'(ifGntA), 16'(vecs[i].expIfGnt));
      checkOutput($sformatf("row%0d lsGnt", i), 16'(lsGntA), 16'(vecs[i].expLsGnt));
      checkOutput($sformatf("row%0d memAddr", i), memAddrA, vecs[i].expAddr);
      checkOutput($sformatf("row%0d memDin", i), memDinA, vecs[i].expDin);
      checkOutput($sformatf("row%0d memWe", i), 16'(memWeA), 16'(vecs[i].expWe));
    end
    repeat (3) @(posedge clk);

    // Single fetch from the preloaded address
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h1222, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("fetch ifGnt", 16'(ifGntA), 16'h0001);
    checkOutput("fetch lsGnt", 16'(lsGntA), 16'h0000);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("fetch N+1 memAddr", memAddrA, 16'h1222);
    checkOutput("fetch N+1 memWe", 16'(memWeA), 16'h0000);
    checkOutput("fetch N+1 ifRvalid", 16'(ifRvalidA), 16'h0000);
    @(negedge clk);
    checkOutput("fetch N+2 ifRvalid", 16'(ifRvalidA), 16'h0001);
    checkOutput("fetch N+2 ifRdata", ifRdataA, 16'h2000);
    checkOutput("fetch N+2 lsRvalid", 16'(lsRvalidA), 16'h0000);
    @(negedge clk);
    checkOutput("fetch N+3 ifRvalid", 16'(ifRvalidA), 16'h0000);
    checkOutput("fetch N+3 ifRdata hold", ifRdataA, 16'h2000);

    // Write then read of the same address on consecutive grants
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0040, 16'hBEEF);
    @(negedge clk);
    checkOutput("wr lsGnt", 16'(lsGntA), 16'h0001);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0040, 16'h0000);
    @(negedge clk);
    checkOutput("rd lsGnt", 16'(lsGntA), 16'h0001);
    checkOutput("wr memWe", 16'(memWeA), 16'h0001);
    checkOutput("wr memAddr", memAddrA, 16'h0040);
    checkOutput("wr memDin", memDinA, 16'hBEEF);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("rd memWe", 16'(memWeA), 16'h0000);
    checkOutput("rd memAddr", memAddrA, 16'h0040);
    checkOutput("wr no lsRvalid", 16'(lsRvalidA), 16'h0000);
    @(negedge clk);
    checkOutput("rd lsRvalid", 16'(lsRvalidA), 16'h0001);
    checkOutput("rd lsRdata", lsRdataA, 16'hBEEF);
    checkOutput("rd ifRvalid", 16'(ifRvalidA), 16'h0000);
    @(negedge clk);
    checkOutput("rd lsRvalid end", 16'(lsRvalidA), 16'h0000);
    checkOutput("rd lsRdata hold", lsRdataA, 16'hBEEF);

    // Reset pulse while a fetch is in flight
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h1222, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("rstmid ifGnt", 16'(ifGntA), 16'h0001);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0060, 16'h7777);
    @(negedge clk);
    checkOutput("rstmid memAddr before", memAddrA, 16'h1222);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    #1;
    checkOutput("rstmid memAddr", memAddrA, 16'h0000);
    checkOutput("rstmid memWe", 16'(memWeA), 16'h0000);
    #1 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rstmid c%0d ifRvalid", c), 16'(ifRvalidA), 16'h0000);
      checkOutput($sformatf("rstmid c%0d lsRvalid", c), 16'(lsRvalidA), 16'h0000);
      checkOutput($sformatf("rstmid c%0d memAddr", c), memAddrA, 16'h0000);
      checkOutput($sformatf("rstmid c%0d memWe", c), 16'(memWeA), 16'h0000);
    end

    // Back-to-back fetches on the latency-0 and latency-2 instances
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      ifReqB  = (c < 8);
      ifAddrB = (c < 8) ? 16'(c) : 16'h0000;
      @(negedge clk);
      if (c < 8) begin
        checkOutput($sformatf("b2b c%0d gnt L0", c), 16'(ifGntB0), 16'h0001);
        checkOutput($sformatf("b2b c%0d gnt L2", c), 16'(ifGntB2), 16'h0001);
      end
      checkOutput($sformatf("b2b c%0d rvalid L0", c), 16'(ifRvalidB0),
                  16'((c >= 1) && (c <= 8)));
      if ((c >= 1) && (c <= 8))
        checkOutput($sformatf("b2b c%0d rdata L0", c), ifRdataB0, 16'(c - 1) ^ 16'hC3C3);
      checkOutput($sformatf("b2b c%0d rvalid L2", c), 16'(ifRvalidB2),
                  16'((c >= 3) && (c <= 10)));
      if ((c >= 3) && (c <= 10))
        checkOutput($sformatf("b2b c%0d rdata L2", c), ifRdataB2, 16'(c - 3) ^ 16'hC3C3);
    end

`ifdef RISC16_ARB_STATS_EN
    // Starvation scenario for 20 cycles, starting from clean counters
    @(negedge clk); #1;
    rst = 1'b0;
    #1 rst = 1'b1;
    checkOutput("stats reset if", ifStallA, 16'h0000);
    checkOutput("stats reset ls", lsStallA, 16'h0000);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0080, 16'h0000);
    repeat (19) @(posedge clk);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("stats if_stall_cnt", ifStallA, 16'd16);
    checkOutput("stats ls_stall_cnt", lsStallA, 16'd4);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
